// File: rtl/prio_pkg.sv
// prio_pkg: shared FSM state type and grant-counter width for the priority/round-robin arbiter
package prio_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int CNT_W = 16;

endpackage

// File: rtl/prio_pick.sv
// prio_pick: combinational downward search with wrap; fixed mode always starts at N-1
module prio_pick #(
    parameter  int N = 8,
    localparam int W = N > 1 ? $clog2(N) : 1
) (
    input  logic [N-1:0] cand,
    input  logic [W-1:0] start,
    input  logic         mode,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [W-1:0] s;

    assign s = mode ? start : W'(N - 1);

    // scan from farthest to nearest so the first set bit at or below s (wrapping) wins
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (cand[(int'(s) - k + N) % N]) begin
                found = 1'b1;
                idx   = W'((int'(s) - k + N) % N);
            end
        end
    end

endmodule

// File: rtl/prio_rr_arbiter.sv
// prio_rr_arbiter: fixed-priority / round-robin arbiter holding each grant until handshake; optional PRIO_GNT_CNT_EN adds a saturating handshake counter
module prio_rr_arbiter
    import prio_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = N > 1 ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             mode,
    input  logic             gnt_ready,
    output logic             gnt_valid,
    output logic [W-1:0]     gnt_idx,
    output logic [N-1:0]     gnt_onehot
`ifdef PRIO_GNT_CNT_EN
    ,
    output logic [CNT_W-1:0] gnt_cnt
`endif
);

    state_t       state_q, state_d;
    logic [W-1:0] idx_q, idx_d, last_q, base, start, pick_idx;
    logic [N-1:0] cand;
    logic         hs, arb, found;

    assign gnt_valid  = state_q == GRANT;
    assign gnt_idx    = idx_q;
    assign gnt_onehot = gnt_valid ? N'(1) << idx_q : '0;
    assign hs         = gnt_valid && gnt_ready;
    assign arb        = state_q == IDLE || hs;
    // on a handshake the outgoing grant becomes the round-robin reference at the same edge
    assign base       = hs ? idx_q : last_q;
    assign start      = base == '0 ? W'(N - 1) : base - W'(1);
    assign cand       = state_q == IDLE ? req : req & ~gnt_onehot;

    prio_pick #(.N(N)) u_pick (
        .cand  (cand),
        .start (start),
        .mode  (mode),
        .found (found),
        .idx   (pick_idx)
    );

    // next state: arbitrate only when idle or on a handshake, otherwise hold the grant
    always_comb begin
        state_d = arb ? (found ? GRANT : IDLE) : state_q;
        idx_d   = arb && found ? pick_idx : idx_q;
    end

    // state, grant index and round-robin history registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (hs) last_q <= idx_q;
        end
    end

`ifdef PRIO_GNT_CNT_EN
    // handshake counter, saturating at all-ones
    always_ff @(posedge clk) begin
        if (rst) gnt_cnt <= '0;
        else if (hs && gnt_cnt != '1) gnt_cnt <= gnt_cnt + 1'b1;
    end
`endif

endmodule
